// File: rtl/inst_fetch_if.sv
// Byte-wide instruction memory port between the fetch unit (master) and the
// memory arbiter (slave).
interface inst_fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_grant;
    logic [7:0]  mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_grant, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_grant, output mem_rdata);
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: assembles a little-endian 32-bit word from four byte reads
// over a shared arbitrated port, holding it for IF/ID until consumed or redirected.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic [4:0]   stall,
    input  logic         br_flag,
    input  logic [31:0]  br_addr,
    inst_fetch_if.master mem,
    output logic [31:0]  if_pc,
    output logic [31:0]  if_inst,
    output logic         if_valid,
    output logic         stall_req
);
    logic [31:0]     pc;
    logic [2:0]      issue_cnt;
    logic [2:0]      recv_cnt;
    logic [3:0][7:0] byte_buf;
    logic            pend;      // a byte granted last active cycle is on mem_rdata now
    logic            issue;
    logic            consume;
    logic            stall_unused;

    assign mem.mem_req  = rdy && !rst && !br_flag && (issue_cnt < 3'd4);
    assign mem.mem_addr = pc + {29'd0, issue_cnt};
    assign stall_unused = |stall[4:1];

    always_comb begin
        if_valid  = (recv_cnt == 3'd4);
        issue     = mem.mem_req && mem.mem_grant;
        consume   = if_valid && !stall[0];
        stall_req = !if_valid;
        if_pc     = pc;
        if_inst   = if_valid ? byte_buf : '0;
    end

    // Redirect outranks consumption; clearing pend drops any byte still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            byte_buf  <= '0;
            pend      <= 1'b0;
        end else if (rdy) begin
            if (br_flag) begin
                pc        <= br_addr;
                issue_cnt <= '0;
                recv_cnt  <= '0;
                byte_buf  <= '0;
                pend      <= 1'b0;
            end else if (consume) begin
                pc        <= pc + 32'd4;
                issue_cnt <= '0;
                recv_cnt  <= '0;
                pend      <= 1'b0;
            end else begin
                pend <= issue;
                if (issue)
                    issue_cnt <= issue_cnt + 3'd1;
                if (pend) begin
                    byte_buf[recv_cnt[1:0]] <= mem.mem_rdata;
                    recv_cnt                <= recv_cnt + 3'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus a randomized run against a
// transaction-level model (PC, granted-byte count, word lookup in a byte memory).
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        rst, rdy, br_flag;
    logic [4:0]  stall;
    logic [31:0] br_addr;
    logic [31:0] if_pc, if_inst;
    logic        if_valid, stall_req;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0]  mem [0:511];
    logic        resp_take;
    logic [31:0] resp_addr;

    logic [31:0] m_pc = 32'h0;
    int unsigned m_cnt = 0;
    bit          m_fresh = 1'b0;

    inst_fetch_if mbus();

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .stall(stall), .br_flag(br_flag),
        .br_addr(br_addr), .mem(mbus), .if_pc(if_pc), .if_inst(if_inst),
        .if_valid(if_valid), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {mem[9'(a + 32'd3)], mem[9'(a + 32'd2)], mem[9'(a + 32'd1)], mem[9'(a)]};
    endfunction

    // Byte memory: answers one cycle after a grant, garbage otherwise, frozen while rdy low.
    always @(posedge clk) begin
        if (rdy) begin
            resp_take = mbus.mem_req && mbus.mem_grant;
            resp_addr = mbus.mem_addr;
            #1 mbus.mem_rdata = resp_take ? mem[resp_addr[8:0]] : 8'($urandom);
        end
    end

    // Reference: m_cnt = bytes granted for the current fetch; word is ready one active edge after the 4th.
    always @(posedge clk) begin
        if (rst) begin
            m_pc = 32'h0; m_cnt = 0; m_fresh = 1'b0;
        end else if (rdy) begin
            if (br_flag) begin
                m_pc = br_addr; m_cnt = 0; m_fresh = 1'b0;
            end else if (m_cnt == 4 && !m_fresh && !stall[0]) begin
                m_pc = m_pc + 32'd4; m_cnt = 0;
            end else begin
                m_fresh = 1'b0;
                if (m_cnt < 4 && mbus.mem_grant) begin
                    m_cnt++;
                    m_fresh = (m_cnt == 4);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; rdy = 1'b1; stall = '0; br_flag = 1'b0; br_addr = '0;
        mbus.mem_grant = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        n_total++; if (mbus.mem_req !== 1'b0) $display("FAIL rst_req: got %b expected 0", mbus.mem_req); else n_pass++;
        n_total++; if (mbus.mem_addr !== 32'h0) $display("FAIL rst_addr: got %h expected 0", mbus.mem_addr); else n_pass++;
        n_total++; if (if_pc !== 32'h0) $display("FAIL rst_pc: got %h expected 0", if_pc); else n_pass++;
        n_total++; if (if_inst !== 32'h0) $display("FAIL rst_inst: got %h expected 0", if_inst); else n_pass++;
        n_total++; if (if_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", if_valid); else n_pass++;
        n_total++; if (stall_req !== 1'b1) $display("FAIL rst_stall_req: got %b expected 1", stall_req); else n_pass++;
    endtask

    task automatic test_basic;
        stall = 5'b00001;
        tick(); rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_total++; if (mbus.mem_addr !== 32'(k)) $display("FAIL basic_addr%0d: got %h expected %h", k, mbus.mem_addr, k); else n_pass++;
            n_total++; if (mbus.mem_req !== 1'b1) $display("FAIL basic_req%0d: got %b expected 1", k, mbus.mem_req); else n_pass++;
            tick();
        end
        @(negedge clk);
        n_total++; if (if_valid !== 1'b0) $display("FAIL basic_early_valid: got %b expected 0", if_valid); else n_pass++;
        n_total++; if (mbus.mem_req !== 1'b0) $display("FAIL basic_req_done: got %b expected 0", mbus.mem_req); else n_pass++;
        tick();
        @(negedge clk);
        n_total++; if (if_valid !== 1'b1) $display("FAIL basic_valid: got %b expected 1", if_valid); else n_pass++;
        n_total++; if (if_inst !== 32'h0000_0513) $display("FAIL basic_inst: got %h expected 00000513", if_inst); else n_pass++;
        n_total++; if (if_pc !== 32'h0) $display("FAIL basic_pc: got %h expected 0", if_pc); else n_pass++;
        n_total++; if (stall_req !== 1'b0) $display("FAIL basic_stall_req: got %b expected 0", stall_req); else n_pass++;
    endtask

    task automatic test_stall;
        for (int k = 0; k < 3; k++) begin
            tick();
            @(negedge clk);
            n_total++; if (if_valid !== 1'b1 || if_inst !== 32'h0000_0513 || if_pc !== 32'h0)
                $display("FAIL stall_hold%0d: got %b/%h/%h expected 1/00000513/0", k, if_valid, if_inst, if_pc); else n_pass++;
            n_total++; if (mbus.mem_req !== 1'b0) $display("FAIL stall_req%0d: got %b expected 0", k, mbus.mem_req); else n_pass++;
        end
        stall = '0;
        tick();
        @(negedge clk);
        n_total++; if (if_pc !== 32'h4) $display("FAIL consume_pc: got %h expected 4", if_pc); else n_pass++;
        n_total++; if (mbus.mem_addr !== 32'h4) $display("FAIL consume_addr: got %h expected 4", mbus.mem_addr); else n_pass++;
        n_total++; if (if_valid !== 1'b0 || if_inst !== 32'h0) $display("FAIL consume_valid: got %b/%h expected 0/0", if_valid, if_inst); else n_pass++;
        n_total++; if (mbus.mem_req !== 1'b1) $display("FAIL consume_req: got %b expected 1", mbus.mem_req); else n_pass++;
    endtask

    task automatic test_branch;
        repeat (3) tick();
        br_flag = 1'b1; br_addr = 32'h100;
        @(negedge clk);
        n_total++; if (mbus.mem_req !== 1'b0) $display("FAIL br_req: got %b expected 0", mbus.mem_req); else n_pass++;
        tick();
        br_flag = 1'b0; stall = 5'b00001;
        @(negedge clk);
        n_total++; if (mbus.mem_addr !== 32'h100) $display("FAIL br_addr: got %h expected 00000100", mbus.mem_addr); else n_pass++;
        n_total++; if (if_pc !== 32'h100 || if_valid !== 1'b0) $display("FAIL br_pc: got %h/%b expected 00000100/0", if_pc, if_valid); else n_pass++;
        repeat (4) tick();
        @(negedge clk);
        n_total++; if (if_valid !== 1'b0) $display("FAIL br_early_valid: got %b expected 0", if_valid); else n_pass++;
        tick();
        @(negedge clk);
        n_total++; if (if_valid !== 1'b1) $display("FAIL br_valid: got %b expected 1", if_valid); else n_pass++;
        n_total++; if (if_inst !== 32'h4433_2211) $display("FAIL br_inst: got %h expected 44332211", if_inst); else n_pass++;
    endtask

    task automatic test_br_priority;
        br_flag = 1'b1; br_addr = 32'h40;
        tick();
        br_flag = 1'b0;
        @(negedge clk);
        n_total++; if (if_pc !== 32'h40 || if_valid !== 1'b0) $display("FAIL brstall_pc: got %h/%b expected 00000040/0", if_pc, if_valid); else n_pass++;
        repeat (4) tick();
        br_flag = 1'b1; br_addr = 32'h80;
        tick();
        br_flag = 1'b0;
        @(negedge clk);
        n_total++; if (if_valid !== 1'b0 || if_inst !== 32'h0) $display("FAIL brdone_valid: got %b/%h expected 0/0", if_valid, if_inst); else n_pass++;
        n_total++; if (if_pc !== 32'h80 || mbus.mem_addr !== 32'h80) $display("FAIL brdone_pc: got %h/%h expected 00000080", if_pc, mbus.mem_addr); else n_pass++;
        stall = '0;
    endtask

    task automatic test_grant_gap;
        int unsigned ga [6] = '{1, 0, 0, 1, 1, 1};
        int unsigned ea [6] = '{0, 1, 1, 1, 2, 3};
        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            mbus.mem_grant = ga[k][0];
            @(negedge clk);
            n_total++; if (mbus.mem_addr !== ea[k] || mbus.mem_req !== 1'b1)
                $display("FAIL gap_addr%0d: got %h/%b expected %h/1", k, mbus.mem_addr, mbus.mem_req, ea[k]); else n_pass++;
            tick();
        end
        @(negedge clk);
        n_total++; if (if_valid !== 1'b0) $display("FAIL gap_early_valid: got %b expected 0", if_valid); else n_pass++;
        tick();
        @(negedge clk);
        n_total++; if (if_valid !== 1'b1 || if_inst !== 32'h0000_0513) $display("FAIL gap_inst: got %b/%h expected 1/00000513", if_valid, if_inst); else n_pass++;
    endtask

    task automatic test_rdy;
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (2) tick();
        rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_total++; if (mbus.mem_req !== 1'b0 || mbus.mem_addr !== 32'h2 || if_valid !== 1'b0 || if_pc !== 32'h0)
                $display("FAIL rdy_freeze%0d: got %b/%h/%b/%h expected 0/2/0/0", k, mbus.mem_req, mbus.mem_addr, if_valid, if_pc); else n_pass++;
            tick();
        end
        rdy = 1'b1;
        @(negedge clk);
        n_total++; if (mbus.mem_req !== 1'b1 || mbus.mem_addr !== 32'h2) $display("FAIL rdy_resume: got %b/%h expected 1/2", mbus.mem_req, mbus.mem_addr); else n_pass++;
        repeat (2) tick();
        @(negedge clk);
        n_total++; if (if_valid !== 1'b0) $display("FAIL rdy_early_valid: got %b expected 0", if_valid); else n_pass++;
        tick();
        @(negedge clk);
        n_total++; if (if_valid !== 1'b1 || if_inst !== 32'h0000_0513) $display("FAIL rdy_inst: got %b/%h expected 1/00000513", if_valid, if_inst); else n_pass++;
    endtask

    task automatic test_reset_mid;
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        @(negedge clk);
        n_total++; if (mbus.mem_req !== 1'b0) $display("FAIL midrst_req: got %b expected 0", mbus.mem_req); else n_pass++;
        tick(); rst = 1'b0;
        @(negedge clk);
        n_total++; if (if_pc !== 32'h0 || mbus.mem_addr !== 32'h0 || stall_req !== 1'b1)
            $display("FAIL midrst_state: got %h/%h/%b expected 0/0/1", if_pc, mbus.mem_addr, stall_req); else n_pass++;
        repeat (5) tick();
        @(negedge clk);
        n_total++; if (if_valid !== 1'b1 || if_inst !== 32'h0000_0513) $display("FAIL midrst_inst: got %b/%h expected 1/00000513", if_valid, if_inst); else n_pass++;
    endtask

    task automatic test_random;
        logic        e_valid, e_req;
        logic [31:0] e_addr, e_inst;
        rst = 1'b1; tick();
        for (int c = 0; c < 3000; c++) begin
            rst            = ($urandom_range(0, 99) == 0);
            rdy            = ($urandom_range(0, 9) != 0);
            mbus.mem_grant = ($urandom_range(0, 3) != 0);
            stall          = {4'($urandom), ($urandom_range(0, 9) < 3)};
            br_flag        = ($urandom_range(0, 29) == 0);
            br_addr        = 32'($urandom_range(0, 511));
            @(negedge clk);
            e_valid = (m_cnt == 4) && !m_fresh;
            e_req   = rdy && !rst && !br_flag && (m_cnt < 4);
            e_addr  = m_pc + m_cnt;
            e_inst  = e_valid ? word_at(m_pc) : 32'h0;
            n_total++; if (mbus.mem_req !== e_req) $display("FAIL rnd_req@%0d: got %b expected %b", c, mbus.mem_req, e_req); else n_pass++;
            n_total++; if (mbus.mem_addr !== e_addr) $display("FAIL rnd_addr@%0d: got %h expected %h", c, mbus.mem_addr, e_addr); else n_pass++;
            n_total++; if (if_pc !== m_pc) $display("FAIL rnd_pc@%0d: got %h expected %h", c, if_pc, m_pc); else n_pass++;
            n_total++; if (if_valid !== e_valid) $display("FAIL rnd_valid@%0d: got %b expected %b", c, if_valid, e_valid); else n_pass++;
            n_total++; if (stall_req !== !e_valid) $display("FAIL rnd_stall_req@%0d: got %b expected %b", c, stall_req, !e_valid); else n_pass++;
            n_total++; if (if_inst !== e_inst) $display("FAIL rnd_inst@%0d: got %h expected %h", c, if_inst, e_inst); else n_pass++;
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h00; mem[3] = 8'h00;
        mem[256] = 8'h11; mem[257] = 8'h22; mem[258] = 8'h33; mem[259] = 8'h44;
        mbus.mem_rdata = 8'h00;
        test_reset();
        test_basic();
        test_stall();
        test_branch();
        test_br_priority();
        test_grant_gap();
        test_rdy();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
